// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing for a 640x480@60 Hz display, clocked by the pixel clock.
// Two free-running counters (hc = column, vc = line) sweep the full raster,
// including blanking. Sync, blank and marker pulses are decoded directly
// from the counters. Delayed copies of hs/vs/blank line the VGA pins up with
// RGB that downstream renderers register PIPE_DELAY cycles after they see
// DrawX/DrawY.
//
// Ports:
//   vga_clk     in   pixel clock (only clock in the block)
//   reset       in   synchronous, active-high; restarts the raster at (0,0)
//   DrawX       out  [9:0] current column, 0..H_TOTAL-1
//   DrawY       out  [9:0] current line,   0..V_TOTAL-1
//   blank       out  1 = visible pixel, 0 = blanking interval
//   hs, vs      out  active-low sync, aligned with DrawX/DrawY
//   frame_start out  high while DrawX=0 and DrawY=0
//   line_end    out  high while DrawX=H_TOTAL-1
//   hs_d, vs_d  out  hs/vs delayed by PIPE_DELAY cycles (drive the VGA pins)
//   blank_d     out  blank delayed by PIPE_DELAY cycles
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic       line_end,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // Value every delay stage holds after reset: hs=1, vs=1, blank=0.
    localparam logic [2:0] PIPE_IDLE = 3'b110;

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;

    // ---------------------------------------------------------------------
    // Raster counters. vc only advances on the column wrap, so both wrap
    // together on the last pixel of the frame.
    // ---------------------------------------------------------------------
    always_comb begin
        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // ---------------------------------------------------------------------
    // Decodes, valid in the same cycle as the counter values.
    // ---------------------------------------------------------------------
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
    assign hs          = !((hc_q >= H_SYNC_BEG) && (hc_q < H_SYNC_END));
    // vs depends only on the line, so it switches together with hc=0.
    assign vs          = !((vc_q >= V_SYNC_BEG) && (vc_q < V_SYNC_END));
    assign frame_start = (hc_q == 10'd0) && (vc_q == 10'd0);
    assign line_end    = (hc_q == H_LAST);

    // ---------------------------------------------------------------------
    // Delay line for {hs, vs, blank}. Stage 0 captures the live decode;
    // the last stage drives the pins. Reset flushes every stage to idle so
    // no sync pulse from before the reset can leak out afterwards.
    // ---------------------------------------------------------------------
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign hs_d    = hs;
            assign vs_d    = vs;
            assign blank_d = blank;
        end else begin : g_delay
            logic [2:0] pipe_q [PIPE_DELAY];
            logic [2:0] pipe_d [PIPE_DELAY];

            always_comb begin
                pipe_d[0] = {hs, vs, blank};
                for (int i = 1; i < PIPE_DELAY; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge vga_clk) begin
                for (int i = 0; i < PIPE_DELAY; i++) begin
                    if (reset) begin
                        pipe_q[i] <= PIPE_IDLE;
                    end else begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign {hs_d, vs_d, blank_d} = pipe_q[PIPE_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// Bench for vga_timing_gen. Three instances share clock and reset:
//   u_def : default 640x480 timing, PIPE_DELAY=2 (line-level checks)
//   u_sm  : shrunken raster 34x17, PIPE_DELAY=5 (frame-level checks)
//   u_p0  : shrunken raster 34x17, PIPE_DELAY=0
// The expected outputs come from a cycle-count model: after n edges since
// reset, x = n mod H_TOTAL and y = (n div H_TOTAL) mod V_TOTAL.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int W = 28;

    localparam int SM_HV = 20, SM_HF = 4, SM_HW = 6, SM_HB = 4;
    localparam int SM_VV = 10, SM_VF = 2, SM_VW = 2, SM_VB = 3;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic [9:0] def_x, def_y, sm_x, sm_y, p0_x, p0_y;
    logic def_blank, def_hs, def_vs, def_fs, def_le, def_hsd, def_vsd, def_bd;
    logic sm_blank, sm_hs, sm_vs, sm_fs, sm_le, sm_hsd, sm_vsd, sm_bd;
    logic p0_blank, p0_hs, p0_vs, p0_fs, p0_le, p0_hsd, p0_vsd, p0_bd;
    logic [W-1:0] def_act, sm_act, p0_act;

    assign def_act = {def_x, def_y, def_blank, def_hs, def_vs, def_fs, def_le, def_hsd, def_vsd, def_bd};
    assign sm_act  = {sm_x, sm_y, sm_blank, sm_hs, sm_vs, sm_fs, sm_le, sm_hsd, sm_vsd, sm_bd};
    assign p0_act  = {p0_x, p0_y, p0_blank, p0_hs, p0_vs, p0_fs, p0_le, p0_hsd, p0_vsd, p0_bd};

    vga_timing_gen u_def (
        .vga_clk(clk), .reset(reset), .DrawX(def_x), .DrawY(def_y),
        .blank(def_blank), .hs(def_hs), .vs(def_vs), .frame_start(def_fs),
        .line_end(def_le), .hs_d(def_hsd), .vs_d(def_vsd), .blank_d(def_bd)
    );

    vga_timing_gen #(
        .H_VISIBLE(SM_HV), .H_FRONT(SM_HF), .H_SYNC(SM_HW), .H_BACK(SM_HB),
        .V_VISIBLE(SM_VV), .V_FRONT(SM_VF), .V_SYNC(SM_VW), .V_BACK(SM_VB),
        .PIPE_DELAY(5)
    ) u_sm (
        .vga_clk(clk), .reset(reset), .DrawX(sm_x), .DrawY(sm_y),
        .blank(sm_blank), .hs(sm_hs), .vs(sm_vs), .frame_start(sm_fs),
        .line_end(sm_le), .hs_d(sm_hsd), .vs_d(sm_vsd), .blank_d(sm_bd)
    );

    vga_timing_gen #(
        .H_VISIBLE(SM_HV), .H_FRONT(SM_HF), .H_SYNC(SM_HW), .H_BACK(SM_HB),
        .V_VISIBLE(SM_VV), .V_FRONT(SM_VF), .V_SYNC(SM_VW), .V_BACK(SM_VB),
        .PIPE_DELAY(0)
    ) u_p0 (
        .vga_clk(clk), .reset(reset), .DrawX(p0_x), .DrawY(p0_y),
        .blank(p0_blank), .hs(p0_hs), .vs(p0_vs), .frame_start(p0_fs),
        .line_end(p0_le), .hs_d(p0_hsd), .vs_d(p0_vsd), .blank_d(p0_bd)
    );

    // ---------------- reference model ----------------
    // Undelayed outputs: {x[9:0], y[9:0], blank, hs, vs, frame_start, line_end}
    function automatic logic [24:0] und(input int n, input int hv, input int hf,
                                        input int hw, input int hb, input int vv,
                                        input int vf, input int vw, input int vb);
        int ht, vt, x, y;
        logic b, h, v, fs, le;
        ht = hv + hf + hw + hb;
        vt = vv + vf + vw + vb;
        x  = n % ht;
        y  = (n / ht) % vt;
        b  = (x < hv) && (y < vv);
        h  = !((x >= hv + hf) && (x < hv + hf + hw));
        v  = !((y >= vv + vf) && (y < vv + vf + vw));
        fs = (x == 0) && (y == 0);
        le = (x == ht - 1);
        return {10'(x), 10'(y), b, h, v, fs, le};
    endfunction

    // Full output vector; delayed bits sit idle (1,1,0) until pd edges after reset.
    function automatic logic [W-1:0] model(input int n, input int pd, input int hv,
                                           input int hf, input int hw, input int hb,
                                           input int vv, input int vf, input int vw,
                                           input int vb);
        logic [24:0] u, p;
        logic [2:0]  d;
        u = und(n, hv, hf, hw, hb, vv, vf, vw, vb);
        if (n >= pd) begin
            p = und(n - pd, hv, hf, hw, hb, vv, vf, vw, vb);
            d = {p[3], p[2], p[4]};
        end else begin
            d = 3'b110;
        end
        return {u, d};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_def_q[$];
    logic [W-1:0] exp_sm_q[$];
    logic [W-1:0] exp_p0_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int n = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s (n=%0d): got %h expected %h", name, n, act, exp);
        end
    endtask

    // Monitors
    int def_hs_run = 0, def_hs_max = 0, sm_hs_run = 0, sm_hs_max = 0;
    int sm_fs_cnt = 0, sm_vsd_low = 0, p0_vsd_low = 0;

    always @(negedge clk) begin
        if (exp_def_q.size() > 0) chk("sb_def", def_act, exp_def_q.pop_front());
        if (exp_sm_q.size() > 0)  chk("sb_sm", sm_act, exp_sm_q.pop_front());
        if (exp_p0_q.size() > 0)  chk("sb_p0", p0_act, exp_p0_q.pop_front());
        if (started) begin
            def_hs_run = def_hs ? 0 : def_hs_run + 1;
            if (def_hs_run > def_hs_max) def_hs_max = def_hs_run;
            sm_hs_run = sm_hs ? 0 : sm_hs_run + 1;
            if (sm_hs_run > sm_hs_max) sm_hs_max = sm_hs_run;
            if (sm_fs) sm_fs_cnt++;
            if (!sm_vsd) sm_vsd_low++;
            if (!p0_vsd) p0_vsd_low++;
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic rst);
        reset = rst;
        @(posedge clk);
        n = rst ? 0 : n + 1;
        started = 1;
        exp_def_q.push_back(model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        exp_sm_q.push_back(model(n, 5, SM_HV, SM_HF, SM_HW, SM_HB, SM_VV, SM_VF, SM_VW, SM_VB));
        exp_p0_q.push_back(model(n, 0, SM_HV, SM_HF, SM_HW, SM_HB, SM_VV, SM_VF, SM_VW, SM_VB));
    endtask

    // ---------------- vector table (default instance) ----------------
    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       blank;
        logic       hs;
        logic       le;
        logic       bd;
    } vec_t;

    vec_t tbl[13];
    int   first_fs;

    initial begin
        tbl[0]  = '{1,    10'd1,   10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2,    10'd2,   10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{639,  10'd639, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{640,  10'd640, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{642,  10'd642, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{655,  10'd655, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{656,  10'd656, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{751,  10'd751, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{752,  10'd752, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{799,  10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{800,  10'd0,   10'd1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{802,  10'd2,   10'd1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{1440, 10'd640, 10'd1, 1'b0, 1'b1, 1'b0, 1'b1};

        reset = 1'b1;

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            #1;
            chk("rst_def", def_act, {20'd0, 8'b1111_0110});
            chk("rst_p0", p0_act, {20'd0, 8'b1111_0111});
        end

        // Walk the first line and a bit of the second.
        for (int i = 0; i < 13; i++) begin
            while (n < tbl[i].n) step(1'b0);
            #1;
            chk($sformatf("vec%0d", tbl[i].n),
                {4'd0, def_x, def_y, def_blank, def_hs, def_le, def_bd},
                {4'd0, tbl[i].x, tbl[i].y, tbl[i].blank, tbl[i].hs, tbl[i].le, tbl[i].bd});
        end

        // Run into the fourth small frame, stop at (10,8) and reset there.
        while (n < 2016) step(1'b0);
        #1;
        chk("sm_pre_rst", {8'd0, sm_x, sm_y}, {8'd0, 10'd10, 10'd8});
        step(1'b1);
        #1;
        chk("sm_rst_xy", {8'd0, sm_x, sm_y}, 28'd0);
        chk("def_rst_xy", {8'd0, def_x, def_y}, 28'd0);
        step(1'b0);
        #1;
        chk("sm_resume", {8'd0, sm_x, sm_y}, {8'd0, 10'd1, 10'd0});

        // Next frame_start on the small raster must follow one frame later.
        first_fs = -1;
        while (n < 700) begin
            step(1'b0);
            #1;
            if (sm_fs && first_fs < 0) first_fs = n;
        end
        chk("sm_frame_period", 28'(first_fs), 28'd578);

        // Reset in the middle of the default hs pulse.
        chk("def_in_hs", {17'd0, def_x, def_hs}, {17'd0, 10'd700, 1'b0});
        step(1'b1);
        sm_fs_cnt  = 0;
        sm_vsd_low = 0;
        p0_vsd_low = 0;
        #1;
        chk("def_hs_rst", {17'd0, def_x, def_hs}, {17'd0, 10'd0, 1'b1});

        // Long run: delay lines, several small frames, many default lines.
        for (int i = 0; i < 2000; i++) step(1'b0);
        @(negedge clk);
        #1;

        chk("sm_fs_count", 28'(sm_fs_cnt), 28'd4);
        chk("sm_vsd_low", 28'(sm_vsd_low), 28'd204);
        chk("p0_vsd_low", 28'(p0_vsd_low), 28'd204);
        chk("def_hs_max", 28'(def_hs_max), 28'd96);
        chk("sm_hs_max", 28'(sm_hs_max), 28'd6);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
